// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC generator port bundle.
//   master : the PC generator (drives pc_o/ce_o/fire_o/addr_err_o/pend_o,
//            receives stall, memory ready and redirect requests)
//   slave  : the surrounding pipeline / instruction memory side
// Signal names keep the direction suffix as seen from the PC generator.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall_i;     // hazard-unit stall
    logic              ready_i;     // imem accepts this cycle
    logic              flush_i;     // exception/ERET redirect
    logic [ADDR_W-1:0] flush_pc_i;
    logic              branch_i;    // branch/jump redirect
    logic [ADDR_W-1:0] branch_pc_i;
    logic [ADDR_W-1:0] pc_o;        // registered fetch address
    logic              ce_o;        // registered fetch enable
    logic              fire_o;      // fetch accepted and not stalled
    logic              addr_err_o;  // misaligned fetch address
    logic              pend_o;      // redirect waiting for a fire

    modport master (
        input  stall_i, ready_i, flush_i, flush_pc_i, branch_i, branch_pc_i,
        output pc_o, ce_o, fire_o, addr_err_o, pend_o
    );

    modport slave (
        output stall_i, ready_i, flush_i, flush_pc_i, branch_i, branch_pc_i,
        input  pc_o, ce_o, fire_o, addr_err_o, pend_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: parametrised IF-stage fetch-PC generator.
// Ports:
//   clk_i  : clock, rising-edge
//   rst_i  : synchronous active-high reset
//   bus    : pc_gen_if master modport (stall/ready/redirect inputs,
//            pc/ce/fire/addr_err/pend outputs)
// After reset the generator sits one cycle in StBoot (ce_o=0), then fetches
// continuously. The PC advances only on fire_o; redirects that arrive while
// the fetch is blocked are parked in a one-entry pending buffer.
module pc_gen #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned PC_INC   = 4
) (
    input logic    clk_i,
    input logic    rst_i,
    pc_gen_if.master bus
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PcInc   = ADDR_W'(PC_INC);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              ce_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              fire;

    assign fire = ce_q & bus.ready_i & ~bus.stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StBoot;
            pc_q      <= ResetPc;
            ce_q      <= 1'b0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            case (state_q)
                StBoot: begin
                    // Branches are ignored here; only a flush may move the
                    // boot address.
                    state_q <= StRun;
                    ce_q    <= 1'b1;
                    if (bus.flush_i) begin
                        pc_q <= bus.flush_pc_i;
                    end
                end
                StRun: begin
                    if (bus.flush_i) begin
                        // Abandons any unaccepted request and any pending
                        // branch, whether or not this cycle fires.
                        pc_q   <= bus.flush_pc_i;
                        pend_q <= 1'b0;
                    end else if (bus.branch_i && fire) begin
                        pc_q   <= bus.branch_pc_i;
                        pend_q <= 1'b0;
                    end else if (bus.branch_i) begin
                        // Blocked: park the target; a newer branch wins.
                        pend_q    <= 1'b1;
                        pend_pc_q <= bus.branch_pc_i;
                    end else if (pend_q && fire) begin
                        pc_q   <= pend_pc_q;
                        pend_q <= 1'b0;
                    end else if (fire) begin
                        // Wraps modulo 2^ADDR_W; misaligned PCs step too.
                        pc_q <= pc_q + PcInc;
                    end
                end
                default: begin
                    state_q <= StBoot;
                    ce_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.ce_o       = ce_q;
    assign bus.fire_o     = fire;
    assign bus.addr_err_o = ce_q & (pc_q[1:0] != 2'b00);
    assign bus.pend_o     = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch;
    logic [31:0] branch_pc;

    int total = 0;
    int bad   = 0;

    pc_gen_if #(.ADDR_W(32)) bus32 ();
    pc_gen_if #(.ADDR_W(16)) bus16 ();

    assign bus32.stall_i     = stall;
    assign bus32.ready_i     = ready;
    assign bus32.flush_i     = flush;
    assign bus32.flush_pc_i  = flush_pc;
    assign bus32.branch_i    = branch;
    assign bus32.branch_pc_i = branch_pc;

    assign bus16.stall_i     = stall;
    assign bus16.ready_i     = ready;
    assign bus16.flush_i     = flush;
    assign bus16.flush_pc_i  = flush_pc[15:0];
    assign bus16.branch_i    = branch;
    assign bus16.branch_pc_i = branch_pc[15:0];

    pc_gen #(
        .ADDR_W  (32),
        .RESET_PC(32'hBFC0_0000),
        .PC_INC  (4)
    ) u_dut32 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus32)
    );

    pc_gen #(
        .ADDR_W  (16),
        .RESET_PC(32'h0000_0100),
        .PC_INC  (4)
    ) u_dut16 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch unit must look like after each edge.
    typedef struct {
        logic        booted;
        logic [31:0] pc;
        logic        pend;
        logic [31:0] tgt;
    } mstate_t;

    function automatic mstate_t m_next(mstate_t s, logic [31:0] mask, logic [31:0] rpc);
        mstate_t n;
        logic    fires;
        n     = s;
        fires = s.booted && ready && !stall;
        if (rst) begin
            n.booted = 1'b0;
            n.pc     = rpc & mask;
            n.pend   = 1'b0;
            n.tgt    = 32'h0;
        end else if (!s.booted) begin
            n.booted = 1'b1;
            if (flush) n.pc = flush_pc & mask;
        end else if (flush) begin
            n.pc   = flush_pc & mask;
            n.pend = 1'b0;
        end else if (branch && fires) begin
            n.pc   = branch_pc & mask;
            n.pend = 1'b0;
        end else if (branch) begin
            n.pend = 1'b1;
            n.tgt  = branch_pc & mask;
        end else if (s.pend && fires) begin
            n.pc   = s.tgt;
            n.pend = 1'b0;
        end else if (fires) begin
            n.pc = (s.pc + 32'd4) & mask;
        end
        return n;
    endfunction

    mstate_t m32;
    mstate_t m16;
    logic    m_valid = 1'b0;

    always @(posedge clk) begin
        m32     = m_next(m32, 32'hFFFF_FFFF, 32'hBFC0_0000);
        m16     = m_next(m16, 32'h0000_FFFF, 32'h0000_0100);
        m_valid = 1'b1;
    end

    // Compare every cycle, half a period away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("pc32", bus32.pc_o, m32.pc);
            check("ce32", {31'b0, bus32.ce_o}, {31'b0, m32.booted});
            check("pend32", {31'b0, bus32.pend_o}, {31'b0, m32.pend});
            check("fire32", {31'b0, bus32.fire_o}, {31'b0, m32.booted & ready & ~stall});
            check("aerr32", {31'b0, bus32.addr_err_o},
                  {31'b0, m32.booted & (m32.pc[1:0] != 2'b00)});
            check("pc16", {16'b0, bus16.pc_o}, m16.pc);
            check("ce16", {31'b0, bus16.ce_o}, {31'b0, m16.booted});
            check("pend16", {31'b0, bus16.pend_o}, {31'b0, m16.pend});
            check("fire16", {31'b0, bus16.fire_o}, {31'b0, m16.booted & ready & ~stall});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input logic ce,
                       input logic pend);
        check({name, "_pc"}, bus32.pc_o, pc);
        check({name, "_ce"}, {31'b0, bus32.ce_o}, {31'b0, ce});
        check({name, "_pend"}, {31'b0, bus32.pend_o}, {31'b0, pend});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ready = 1'b1;
        flush = 1'b0; flush_pc = '0; branch = 1'b0; branch_pc = '0;

        // 1. reset and boot
        for (int i = 0; i < 3; i++) step();
        lit("rst", 32'hBFC0_0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(); lit("boot", 32'hBFC0_0000, 1'b1, 1'b0);
        check("boot16", {16'b0, bus16.pc_o}, 32'h0000_0100);
        step(); lit("seq1", 32'hBFC0_0004, 1'b1, 1'b0);
        check("seq16", {16'b0, bus16.pc_o}, 32'h0000_0104);
        step(); lit("seq2", 32'hBFC0_0008, 1'b1, 1'b0);
        step(); step(); lit("at10", 32'hBFC0_0010, 1'b1, 1'b0);

        // 2. stall, then not-ready hold
        stall = 1'b1;
        step(); lit("stall1", 32'hBFC0_0010, 1'b1, 1'b0);
        step(); lit("stall2", 32'hBFC0_0010, 1'b1, 1'b0);
        stall = 1'b0; ready = 1'b0;
        step(); lit("nrdy1", 32'hBFC0_0010, 1'b1, 1'b0);
        step(); lit("nrdy2", 32'hBFC0_0010, 1'b1, 1'b0);
        ready = 1'b1;
        step(); lit("resume", 32'hBFC0_0014, 1'b1, 1'b0);
        step(); step(); step(); lit("at20", 32'hBFC0_0020, 1'b1, 1'b0);

        // 3. blocked branch
        ready = 1'b0; branch = 1'b1; branch_pc = 32'h8000_1000;
        step(); lit("blkbr", 32'hBFC0_0020, 1'b1, 1'b1);
        branch = 1'b0; ready = 1'b1;
        step(); lit("pendgo", 32'h8000_1000, 1'b1, 1'b0);

        // 4. flush beats branch and pending
        ready = 1'b0; branch = 1'b1; branch_pc = 32'h8000_3000;
        step(); lit("pend2", 32'h8000_1000, 1'b1, 1'b1);
        flush = 1'b1; flush_pc = 32'hBFC0_0380; branch_pc = 32'h8000_2000;
        step(); lit("flush", 32'hBFC0_0380, 1'b1, 1'b0);
        flush = 1'b0; branch = 1'b0; ready = 1'b1;
        step(); lit("postfl", 32'hBFC0_0384, 1'b1, 1'b0);

        // 5. wrap
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        step(); lit("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        check("top16", {16'b0, bus16.pc_o}, 32'h0000_FFFC);
        flush = 1'b0;
        step(); lit("wrap", 32'h0000_0000, 1'b1, 1'b0);
        check("wrap16", {16'b0, bus16.pc_o}, 32'h0000_0000);

        // 6. misaligned fetch, then reset while a branch is pending
        flush = 1'b1; flush_pc = 32'h8000_0002;
        step(); lit("mis", 32'h8000_0002, 1'b1, 1'b0);
        check("aerr", {31'b0, bus32.addr_err_o}, 32'h1);
        flush = 1'b0;
        step(); lit("mis4", 32'h8000_0006, 1'b1, 1'b0);
        ready = 1'b0; branch = 1'b1; branch_pc = 32'h1234_5678;
        step(); lit("pend3", 32'h8000_0006, 1'b1, 1'b1);
        branch = 1'b0; rst = 1'b1;
        step(); lit("rstpend", 32'hBFC0_0000, 1'b0, 1'b0);
        check("aerr_rst", {31'b0, bus32.addr_err_o}, 32'h0);
        rst = 1'b0; ready = 1'b1;
        step(); lit("reboot", 32'hBFC0_0000, 1'b1, 1'b0);
        step(); lit("reseq", 32'hBFC0_0004, 1'b1, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
